// File: rtl/fx_pt_pkg.sv
// Shared fixed-point definitions for the unsigned Q4.17 multiplier datapath.
package fx_pt_pkg;

    localparam int part_1_len = 4;
    localparam int part_2_len = 17;
    localparam int word_len   = part_1_len + part_2_len;

    typedef logic [word_len-1:0] fx_word_t;

    localparam fx_word_t SAT_VALUE = '1;

endpackage

// File: rtl/fx_pt_mul.sv
// Combinational unsigned Q4.17 multiplier core: round half-up, saturate to all-ones.
module fx_pt_mul
    import fx_pt_pkg::*;
(
    input  fx_word_t in1,
    input  fx_word_t in2,
    output fx_word_t out,
    output logic     sat
);

    // One spare bit above the full product so the rounding increment never wraps.
    localparam int PW = 2 * word_len + 1;

    logic [PW-1:0] prod;
    logic [PW-1:0] rounded;
    logic [PW-1:0] scaled;

    always_comb begin
        prod    = PW'(in1) * PW'(in2);
        rounded = prod + (PW'(1) << (part_2_len - 1));
        scaled  = rounded >> part_2_len;
        sat     = |scaled[PW-1:word_len];
        out     = sat ? SAT_VALUE : scaled[word_len-1:0];
    end

endmodule

// File: rtl/fx_pt_mul_sched.sv
// Round-robin scheduler sharing one fx_pt_mul core among NUM_REQ requesters,
// with a PIPE_STAGES-deep result pipeline and a sticky saturation counter.

module rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic [W-1:0] idx;

    // Scan from the farthest offset down so the request closest to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = W'((int'(ptr) + off) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

module fx_pt_mul_sched
    import fx_pt_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][word_len-1:0]  req_in1,
    input  logic [NUM_REQ-1:0][word_len-1:0]  req_in2,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              rsp_valid,
    output logic [ID_W-1:0]                   rsp_id,
    output fx_word_t                          rsp_data,
    output logic                              rsp_sat,
    input  logic                              sat_clr,
    output logic [15:0]                       sat_count,
    output logic                              busy
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               accept;

    logic               s0_valid;
    logic [ID_W-1:0]    s0_id;
    fx_word_t           s0_in1;
    fx_word_t           s0_in2;

    fx_word_t           mul_data;
    logic               mul_sat;

    rr_arb #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign req_ready = rst ? '0 : gnt;
    assign accept    = |req_ready;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    // Operands are only loaded on an accept; the valid bit alone marks the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            s0_valid <= 1'b0;
            s0_id    <= '0;
            s0_in1   <= '0;
            s0_in2   <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_id  <= gnt_id;
                s0_in1 <= req_in1[gnt_id];
                s0_in2 <= req_in2[gnt_id];
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end
        end
    end

    fx_pt_mul u_mul (
        .in1 (s0_in1),
        .in2 (s0_in2),
        .out (mul_data),
        .sat (mul_sat)
    );

    generate
        if (PIPE_STAGES == 1) begin : g_pipe_short
            assign rsp_valid = s0_valid;
            assign rsp_id    = s0_id;
            assign rsp_data  = mul_data;
            assign rsp_sat   = s0_valid & mul_sat;
            assign busy      = s0_valid;
        end else begin : g_pipe
            logic [PIPE_STAGES-1:1] pv;
            logic [PIPE_STAGES-1:1] ps;
            logic [ID_W-1:0]        pid [1:PIPE_STAGES-1];
            fx_word_t               pd  [1:PIPE_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                    ps <= '0;
                    for (int k = 1; k < PIPE_STAGES; k++) begin
                        pid[k] <= '0;
                        pd[k]  <= '0;
                    end
                end else begin
                    pv[1]  <= s0_valid;
                    ps[1]  <= s0_valid & mul_sat;
                    pid[1] <= s0_id;
                    pd[1]  <= mul_data;
                    for (int k = 2; k < PIPE_STAGES; k++) begin
                        pv[k]  <= pv[k-1];
                        ps[k]  <= ps[k-1];
                        pid[k] <= pid[k-1];
                        pd[k]  <= pd[k-1];
                    end
                end
            end

            assign rsp_valid = pv[PIPE_STAGES-1];
            assign rsp_id    = pid[PIPE_STAGES-1];
            assign rsp_data  = pd[PIPE_STAGES-1];
            assign rsp_sat   = ps[PIPE_STAGES-1];
            assign busy      = s0_valid | (|pv);
        end
    endgenerate

    // A clear in the same cycle as a saturating response wins and drops the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (rsp_valid && rsp_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
            hold_valid_until_grant: assert property (
                @(posedge clk) disable iff (rst)
                (req_valid[g] && !req_ready[g]) |=> req_valid[g]
            );
        end
    endgenerate

endmodule

// File: doc/fx_pt_mul_sched.md
# fx_pt_mul_sched

Round-robin scheduler that shares one fixed-point multiplier core among `NUM_REQ` requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants at most one request per cycle and pushes it through a `PIPE_STAGES`-deep registered pipeline around the combinational `fx_pt_mul` core. It returns the rounded, saturated product tagged with the requester ID. It sits between the arithmetic-unit clients and the single shared multiplier, and keeps a saturation-event counter for software visibility.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `PIPE_STAGES`, default 2: request-to-response latency in cycles, minimum 1.
- `ID_W`, default `$clog2(NUM_REQ)`: requester-tag width.
- `clk`, input, 1: single clock, all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_in1`, input, `NUM_REQ`×`word_len`: operand A per requester, unsigned Q4.17.
- `req_in2`, input, `NUM_REQ`×`word_len`: operand B per requester, unsigned Q4.17.
- `req_ready`, output, `NUM_REQ`: one-hot grant. A request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, output, 1: one-cycle result strobe. There is no backpressure.
- `rsp_id`, output, `ID_W`: requester index of the result.
- `rsp_data`, output, `word_len`: rounded, saturated product, Q4.17.
- `rsp_sat`, output, 1: set when `rsp_data` was saturated.
- `sat_clr`, input, 1: clears `sat_count`.
- `sat_count`, output, 16: number of saturated results, sticky at 0xFFFF.
- `busy`, output, 1: set when any pipeline stage holds a valid entry.

## Operation
- **Grant rule:** `req_ready` is combinational from `req_valid` and the round-robin pointer `rr_ptr`.
  - The grant goes to the first asserted `req_valid[k]`, searching upward from `k = rr_ptr` and wrapping modulo `NUM_REQ`.
  - When no request is valid, `req_ready = 0`.
- **Pointer update:** on each accepted request from requester `i`, `rr_ptr` becomes `(i+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- **Requester obligations:**
  - Once `req_valid[i]` is asserted, the requester must hold `req_valid[i]` and the operands stable until it is granted.
  - Dropping `req_valid` before the grant is a protocol violation, flagged by an assertion.
- **Stage 0 capture:** captures `{valid, id, in1, in2}` of the granted request.
- **Multiply stage:** the multiply happens combinationally between stage 0 and stage 1.
  - The full product is 2·`word_len` bits.
  - Rounding: round half-up on bit `part_2_len-1`.
  - Saturation: if any bit at or above `word_len` of the rounded value is set, the result is all-ones and `sat = 1`.
- **Remaining stages:** stages 1..`PIPE_STAGES`-1 are plain shift registers for `{valid, id, data, sat}`. The last stage drives the `rsp_*` outputs.
- **Operand format:** all arithmetic is unsigned. Signed operands are not supported.
- **`sat_count`:**
  - Increments when `rsp_valid & rsp_sat`.
  - Stops at 0xFFFF.
  - `sat_clr` takes priority: if `sat_clr` and a saturating response occur in the same cycle, the result is 0 and the event is dropped.
- **Reset:**
  - Clears `rr_ptr` to 0, all stage valid bits, and `sat_count`.
  - Reset mid-operation discards every in-flight result, with no `rsp_valid` for them.
  - `req_ready = 0` while `rst` is high.

## Timing
- **Latency:** a request accepted at edge T gives `rsp_valid` high during the cycle after edge T+`PIPE_STAGES`-1. Equivalently, the response appears `PIPE_STAGES` cycles after the acceptance cycle.
- **Throughput:** one accept per cycle and one response per cycle. There are no bubbles.
- **Ordering:** responses come out in grant order.
- **Reset values:**
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`, `rsp_sat = 0`.
  - `sat_count = 0`, `busy = 0`, `req_ready = 0`.
- **`busy`:** the OR of all stage valid bits. It is registered-derived and has no dependence on `req_valid`.

## Structure
- **Shared package `fx_pt_pkg`:**
  - `part_1_len = 4`, `part_2_len = 17`, `word_len = 21`.
  - `typedef logic [word_len-1:0] fx_word_t`.
  - `SAT_VALUE = '1`.
- **Sub-module:** one instance of the existing `fx_pt_mul` combinational core between stage 0 and stage 1. It must not be reimplemented.
- **Arbiter logic:** a small round-robin arbiter, `rr_arb`, with inputs `req` and `ptr` and output one-hot `gnt`. It may live as a separate module in the same file.

## Test plan
1. **Single multiply:** requester 1 sends 0x30000 × 0x40000 (1.5 × 2.0) → after `PIPE_STAGES` cycles, `rsp_valid = 1`, `rsp_id = 1`, `rsp_data = 0x60000`, `rsp_sat = 0`.
2. **Rounding:** 0x00001 × 0x10000 → `rsp_data = 0x00001`. Then 0x00001 × 0x0FFFF → `rsp_data = 0x00000`.
3. **Saturation:** 0x100000 × 0x40000 (8.0 × 2.0) → `rsp_data = 0x1FFFFF`, `rsp_sat = 1`, `sat_count = 1`. A second such request in the same cycle as `sat_clr` → `sat_count = 0`.
4. **Fairness:** requesters 0 and 2 hold valid continuously for 6 cycles → grant order 0, 2, 0, 2, 0, 2. `rsp_id` follows the same sequence with back-to-back `rsp_valid`.
5. **Wrap-around:** only requester 3 (`NUM_REQ = 4`) is granted, then requesters 0 and 3 request together → requester 0 is granted first.
6. **Reset mid-flight:** issue 2 requests, then assert `rst` for 1 cycle before either response → no `rsp_valid` ever appears for them, `busy = 0`, and the next grant goes to requester 0.
